// File: rtl/laser_frame_ctrl.sv
// Frame controller: buffers PT_NUM points (stall via IN_READY), streams them to the core 1 cycle after the last transfer, and holds the result until OUT_READY.
// Optional watchdog abort in WAIT is compiled in with `define LASER_CTRL_TIMEOUT_EN; without it WAIT exits only on CORE_DONE.
module laser_frame_ctrl #(
    parameter int PT_NUM      = 40,
    parameter int DATA_WIDTH  = 4,
    parameter int TIMEOUT_W   = 16,
    parameter int TIMEOUT_CYC = 40000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  IN_VALID,
    output logic                  IN_READY,
    input  logic [DATA_WIDTH-1:0] IN_X,
    input  logic [DATA_WIDTH-1:0] IN_Y,
    output logic                  CORE_RST,
    output logic [DATA_WIDTH-1:0] CORE_X,
    output logic [DATA_WIDTH-1:0] CORE_Y,
    input  logic [DATA_WIDTH-1:0] CORE_C1X,
    input  logic [DATA_WIDTH-1:0] CORE_C1Y,
    input  logic [DATA_WIDTH-1:0] CORE_C2X,
    input  logic [DATA_WIDTH-1:0] CORE_C2Y,
    input  logic                  CORE_DONE,
    output logic                  OUT_VALID,
    input  logic                  OUT_READY,
    output logic [DATA_WIDTH-1:0] OUT_C1X,
    output logic [DATA_WIDTH-1:0] OUT_C1Y,
    output logic [DATA_WIDTH-1:0] OUT_C2X,
    output logic [DATA_WIDTH-1:0] OUT_C2Y,
    output logic                  OUT_ERR,
    output logic                  BUSY
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_STREAM,
        S_WAIT,
        S_HOLD
    } state_t;

    localparam logic [5:0] LAST_IDX = 6'(PT_NUM - 1);

    state_t state;
    state_t state_nxt;

    logic [5:0]              load_cnt;
    logic [5:0]              stream_cnt;
    logic [5:0]              stream_nxt;
    logic [5:0]              wr_idx;
    logic [2*DATA_WIDTH-1:0] pt_buf [PT_NUM];
    logic                    xfer;
    logic                    timeout_hit;

    assign xfer       = IN_VALID && IN_READY;
    assign wr_idx     = (state == S_IDLE) ? 6'd0 : load_cnt;
    assign stream_nxt = stream_cnt + 6'd1;

`ifdef LASER_CTRL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wdog;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wdog <= '0;
        end else if (state == S_WAIT) begin
            wdog <= wdog + 1'b1;
        end else begin
            wdog <= '0;
        end
    end

    assign timeout_hit = (state == S_WAIT) && (wdog == TIMEOUT_W'(TIMEOUT_CYC - 1));
`else
    // Watchdog parameters stay on the interface so both builds share one instantiation.
    logic [TIMEOUT_W-1:0] unused_timeout_cfg;
    assign unused_timeout_cfg = TIMEOUT_W'(TIMEOUT_CYC);
    assign timeout_hit        = 1'b0;
`endif

    // Buffer has no reset: every frame overwrites all PT_NUM entries before streaming.
    always_ff @(posedge CLK) begin
        if (xfer) begin
            pt_buf[wr_idx] <= {IN_X, IN_Y};
        end
    end

    always_comb begin
        state_nxt = state;
        IN_READY  = 1'b0;
        OUT_VALID = 1'b0;
        BUSY      = (state != S_IDLE);
        case (state)
            S_IDLE: begin
                IN_READY = 1'b1;
                if (xfer) state_nxt = S_LOAD;
            end
            S_LOAD: begin
                IN_READY = 1'b1;
                if (xfer && (load_cnt == LAST_IDX)) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (stream_cnt == LAST_IDX) state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (CORE_DONE || timeout_hit) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                OUT_VALID = 1'b1;
                if (OUT_READY) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state      <= S_IDLE;
            load_cnt   <= '0;
            stream_cnt <= '0;
            CORE_RST   <= 1'b1;
            CORE_X     <= '0;
            CORE_Y     <= '0;
            OUT_C1X    <= '0;
            OUT_C1Y    <= '0;
            OUT_C2X    <= '0;
            OUT_C2Y    <= '0;
            OUT_ERR    <= 1'b0;
        end else begin
            state    <= state_nxt;
            CORE_RST <= !((state_nxt == S_STREAM) || (state_nxt == S_WAIT));
            case (state)
                S_IDLE: begin
                    if (xfer) load_cnt <= 6'd1;
                end
                S_LOAD: begin
                    if (xfer) begin
                        load_cnt <= load_cnt + 6'd1;
                        if (load_cnt == LAST_IDX) begin
                            // The first point is already stored, so it goes out on the entry edge.
                            stream_cnt       <= '0;
                            {CORE_X, CORE_Y} <= pt_buf[0];
                        end
                    end
                end
                S_STREAM: begin
                    if (stream_cnt != LAST_IDX) begin
                        stream_cnt       <= stream_nxt;
                        {CORE_X, CORE_Y} <= pt_buf[stream_nxt];
                    end
                end
                S_WAIT: begin
                    if (CORE_DONE) begin
                        OUT_C1X <= CORE_C1X;
                        OUT_C1Y <= CORE_C1Y;
                        OUT_C2X <= CORE_C2X;
                        OUT_C2Y <= CORE_C2Y;
                        OUT_ERR <= 1'b0;
                    end else if (timeout_hit) begin
                        OUT_C1X <= '0;
                        OUT_C1Y <= '0;
                        OUT_C2X <= '0;
                        OUT_C2Y <= '0;
                        OUT_ERR <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/laser_frame_ctrl.md
# laser_frame_ctrl

Frame controller that sequences the two-circle laser coverage core. It accepts a 40-point frame over a stallable valid/ready input and buffers it locally. It then holds the core in reset and replays the frame on 40 back-to-back cycles, which is what the core's load phase requires. It captures the core's one-cycle DONE result and presents it on a valid/ready output, guarded by an optional watchdog.

## Interface
Parameters:
- PT_NUM, 40, points per frame; must match the core's point count.
- DATA_WIDTH, 4, coordinate width.
- TIMEOUT_W, 16, watchdog counter width.
- TIMEOUT_CYC, 40000, maximum cycles spent in WAIT before abort.

Ports:
- CLK, input, 1, single clock; all logic on the rising edge.
- RST, input, 1, asynchronous, active-high reset.
- IN_VALID, input, 1, the input point is valid.
- IN_READY, output, 1, the controller accepts a point this cycle.
- IN_X, IN_Y, input, DATA_WIDTH each, point coordinates.
- CORE_RST, output, 1, registered; synchronous reset to the core.
- CORE_X, CORE_Y, output, DATA_WIDTH each, registered; point stream to the core.
- CORE_C1X, CORE_C1Y, CORE_C2X, CORE_C2Y, input, DATA_WIDTH each, core result.
- CORE_DONE, input, 1, one-cycle result pulse from the core.
- OUT_VALID, output, 1, a result is held.
- OUT_READY, input, 1, the consumer takes the result.
- OUT_C1X, OUT_C1Y, OUT_C2X, OUT_C2Y, output, DATA_WIDTH each, captured centres.
- OUT_ERR, output, 1, the result was aborted by the watchdog.
- BUSY, output, 1, the state is not IDLE.

## Operation
- Buffer: PT_NUM×(2·DATA_WIDTH) register file, written at index load_cnt; load_cnt and stream_cnt are 6 bits.
- IN_READY = 1 only in IDLE and LOAD. A transfer occurs when IN_VALID && IN_READY.
- The state machine has five states:
  - IDLE: on a transfer, write buf[0], load_cnt←1, go to LOAD.
  - LOAD: on each transfer, write buf[load_cnt] and increment load_cnt. On the transfer with load_cnt==PT_NUM-1, go to STREAM with stream_cnt←0. Gaps in IN_VALID stall the count; there is no timeout in LOAD.
  - STREAM: CORE_RST=0; CORE_X/Y = buf[stream_cnt] on PT_NUM consecutive cycles. After the last point, go to WAIT.
  - WAIT: wdog counts up each cycle.
    - On CORE_DONE: capture CORE_C* into OUT_C*, OUT_ERR←0, go to HOLD.
    - On wdog==TIMEOUT_CYC-1 without CORE_DONE: OUT_C*←0, OUT_ERR←1, go to HOLD.
    - If both occur in the same cycle, CORE_DONE wins.
  - HOLD: OUT_VALID=1 and OUT_* are stable. On OUT_READY, go to IDLE.
- CORE_RST=1 in every state except STREAM and WAIT, so the core is parked in reset between frames. Leaving WAIT reasserts it.
- CORE_DONE outside WAIT is ignored.
- CORE_X/Y hold their last value outside STREAM.
- The buffer is not cleared between frames; each frame fully overwrites it.

## Timing
- Reset values: IN_READY=1 after release (state IDLE), CORE_RST=1, CORE_X/Y=0, OUT_VALID=0, OUT_C*=0, OUT_ERR=0, BUSY=0. load_cnt, stream_cnt and wdog are 0.
- Asserting RST mid-frame aborts immediately. CORE_RST goes to 1 asynchronously and any partial frame is discarded.
- STREAM entry: on the edge after the last input transfer, CORE_RST falls and CORE_X/Y show buf[0] on the same edge. buf[k] is presented on the k-th cycle after entry.
- Minimum frame-to-core latency is 1 cycle after the last transfer, then PT_NUM cycles of stream.
- OUT_VALID rises on the edge after the CORE_DONE sample.
- With OUT_READY tied high, HOLD lasts 1 cycle and IDLE accepts the next frame on the following cycle.
- There are no combinational paths from inputs to outputs except IN_READY and OUT_VALID, which are decoded from state only.

## Configuration
- LASER_CTRL_TIMEOUT_EN:
  - Defined: the wdog counter and abort path are compiled in, as described above.
  - Undefined: there is no wdog counter, WAIT exits only on CORE_DONE, and OUT_ERR is tied to 0.

## Test plan
- Reset, then 40 points with IN_VALID held high: CORE_RST falls 1 cycle after the 40th transfer, and CORE_X/Y match the inputs in order for 40 cycles.
- Same frame with IN_VALID toggled 1010…: identical CORE_X/Y sequence, and IN_READY stays 1 through LOAD.
- Core model pulses CORE_DONE with C1=(3,4), C2=(9,11): next edge shows OUT_VALID=1, OUT_C1X/Y=3/4, OUT_C2X/Y=9/11, OUT_ERR=0.
  - With OUT_READY held low for 5 cycles, the outputs stay stable and IN_READY=0.
- TIMEOUT_CYC=100 and no CORE_DONE: OUT_VALID rises after 100 WAIT cycles with OUT_ERR=1 and OUT_C*=0.
  - With the macro undefined, the controller stays in WAIT indefinitely.
- CORE_DONE on the wdog terminal cycle: OUT_ERR=0 and the captured result is presented.
- RST pulsed after 20 streamed points: CORE_RST=1 immediately and BUSY=0. A following full frame streams all 40 new points correctly.
